// File: rtl/core_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32 control unit.
package core_ctrl_pkg;

  localparam int unsigned OP_W       = 7;
  localparam int unsigned F3_W       = 3;
  localparam int unsigned FLAG_W     = 4;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned SEL_W      = 2;

  // Bit positions inside flags = {N, Z, C, V}; Z is 1 when the result is non-zero
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0100;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  // Immediate format for an opcode; anything without a special format uses I
  function automatic logic [SEL_W-1:0] imm_src(input logic [OP_W-1:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode for R/I-type instructions, flagging unsupported funct3.
module alu_decoder
  import core_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]       op,
  input  logic [F3_W-1:0]       funct3,
  input  logic                  funct7b5,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  aluIllegal
);

  // funct7b5 selects SUB only for R-type; on I-type it is immediate data
  always_comb begin
    ALUControl = ALU_ADD;
    aluIllegal = 1'b0;
    case (funct3)
      3'b000:  if ((op == OP_RTYPE) && funct7b5) ALUControl = ALU_SUB;
      3'b010:  ALUControl = ALU_SLT;
      3'b110:  ALUControl = ALU_OR;
      3'b111:  ALUControl = ALU_AND;
      default: aluIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM. Define BRANCH_EXT_EN to add bne/blt/bge/bltu/bgeu.
module multicycle_ctrl
  import core_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OP_W-1:0]       op,
  input  logic [F3_W-1:0]       funct3,
  input  logic                  funct7b5,
  input  logic [FLAG_W-1:0]     flags,
  input  logic                  memReady,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [SEL_W-1:0]      ResultSrc,
  output logic [SEL_W-1:0]      ALUSrcA,
  output logic [SEL_W-1:0]      ALUSrcB,
  output logic [SEL_W-1:0]      ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  illegalInstr
);

  state_t                  state;
  state_t                  next_state;
  logic [ALU_CTRL_W-1:0]   dec_alu_control;
  logic                    alu_illegal;
  logic                    branch_taken;
  logic                    branch_legal;

  alu_decoder u_alu_decoder (
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUControl (dec_alu_control),
    .aluIllegal (alu_illegal)
  );

  assign ImmSrc = imm_src(op);

`ifdef BRANCH_EXT_EN
  // Branch condition from the SUB flags; Z high means the operands differ
  always_comb begin
    branch_taken = 1'b0;
    branch_legal = 1'b1;
    case (funct3)
      3'b000:  branch_taken = ~flags[FLAG_Z];
      3'b001:  branch_taken = flags[FLAG_Z];
      3'b100:  branch_taken = flags[FLAG_N] ^ flags[FLAG_V];
      3'b101:  branch_taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
      3'b110:  branch_taken = ~flags[FLAG_C];
      3'b111:  branch_taken = flags[FLAG_C];
      default: branch_legal = 1'b0;
    endcase
  end
`else
  // Only beq: taken when the difference is zero
  logic unused_flag_bits;
  assign unused_flag_bits = ^{flags[FLAG_N], flags[FLAG_C], flags[FLAG_V]};
  assign branch_legal     = (funct3 == 3'b000);
  assign branch_taken     = ~flags[FLAG_Z];
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  // Next-state and Moore output decode, with enables gated off during reset
  always_comb begin
    next_state   = state;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    ALUControl   = ALU_ADD;
    illegalInstr = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = memReady;
        PCWrite   = memReady;
        if (memReady) next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECUTER;
          OP_ITYPE:          next_state = S_EXECUTEI;
          OP_BRANCH:         next_state = branch_legal ? S_BRANCH : S_TRAP;
          OP_JAL:            next_state = S_JAL;
          default:           next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (memReady) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (memReady) next_state = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = dec_alu_control;
        next_state = alu_illegal ? S_TRAP : S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = dec_alu_control;
        next_state = alu_illegal ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_SUB;
        PCWrite    = branch_taken;
        next_state = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        next_state = S_ALUWB;
      end
      S_TRAP: begin
        illegalInstr = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
    if (!rst_n) begin
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      MemWrite     = 1'b0;
      RegWrite     = 1'b0;
      illegalInstr = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; define BRANCH_EXT_EN to cover extended branches.
module tb_multicycle_ctrl;

  typedef logic [17:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic [3:0] flags = 4'b0000;
  logic       memReady = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0] ALUControl;
  vec_t       outs;
  int         vectors = 0;
  int         miscompares = 0;

  multicycle_ctrl dut (
    .clk (clk), .rst_n (rst_n), .op (op), .funct3 (funct3), .funct7b5 (funct7b5),
    .flags (flags), .memReady (memReady), .PCWrite (PCWrite), .AdrSrc (AdrSrc),
    .MemWrite (MemWrite), .IRWrite (IRWrite), .RegWrite (RegWrite),
    .ResultSrc (ResultSrc), .ALUSrcA (ALUSrcA), .ALUSrcB (ALUSrcB), .ImmSrc (ImmSrc),
    .ALUControl (ALUControl), .illegalInstr (illegalInstr)
  );

  always #5 clk = ~clk;

  assign outs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUControl, illegalInstr, ImmSrc};

  // Expected output vector, fields in the same order as outs
  function automatic vec_t pk(input logic pcw, adr, mw, irw, rw, input logic [1:0] rs, sa, sb,
                              input logic [3:0] alu, input logic ill, input logic [1:0] imm);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, ill, imm};
  endfunction

  function automatic vec_t v_rst(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'b0000, 0, imm);
  endfunction
  function automatic vec_t v_fetch(input logic mr, input logic [1:0] imm);
    return pk(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 4'b0000, 0, imm);
  endfunction
  function automatic vec_t v_decode(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'b0000, 0, imm);
  endfunction
  function automatic vec_t v_memadr(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'b0000, 0, imm);
  endfunction
  function automatic vec_t v_memread(input logic [1:0] imm);
    return pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 0, imm);
  endfunction
  function automatic vec_t v_memwb(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'b0000, 0, imm);
  endfunction
  function automatic vec_t v_memwrite(input logic [1:0] imm);
    return pk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 0, imm);
  endfunction
  function automatic vec_t v_execr(input logic [3:0] alu, input logic [1:0] imm);
    return pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 0, imm);
  endfunction
  function automatic vec_t v_execi(input logic [3:0] alu, input logic [1:0] imm);
    return pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 0, imm);
  endfunction
  function automatic vec_t v_aluwb(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'b0000, 0, imm);
  endfunction
  function automatic vec_t v_branch(input logic t, input logic [1:0] imm);
    return pk(t, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'b0001, 0, imm);
  endfunction
  function automatic vec_t v_jal(input logic [1:0] imm);
    return pk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'b0000, 0, imm);
  endfunction
  function automatic vec_t v_trap(input logic [1:0] imm);
    return pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'b0000, 1, imm);
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst_n = 1'b0; op = 7'b0000011; memReady = (i == 0); #1;
      vectors++;
      if (outs !== v_rst(2'b00)) begin
        $display("FAIL reset[%0d]: got %h expected %h", i, outs, v_rst(2'b00));
        miscompares++;
      end
    end
  endtask

  task automatic test_lw();
    vec_t exp [5];
    exp = '{v_fetch(1, 2'b00), v_decode(2'b00), v_memadr(2'b00), v_memread(2'b00), v_memwb(2'b00)};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst_n = 1'b1; op = 7'b0000011; funct3 = 3'b010; memReady = 1'b1; #1;
      vectors++;
      if (outs !== exp[i]) begin
        $display("FAIL lw[%0d]: got %h expected %h", i, outs, exp[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_sw_stall();
    vec_t exp [7];
    logic mr [7];
    exp = '{v_fetch(1, 2'b01), v_decode(2'b01), v_memadr(2'b01), v_memwrite(2'b01),
            v_memwrite(2'b01), v_memwrite(2'b01), v_memwrite(2'b01)};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      rst_n = 1'b1; op = 7'b0100011; funct3 = 3'b010; memReady = mr[i]; #1;
      vectors++;
      if (outs !== exp[i]) begin
        $display("FAIL sw_stall[%0d]: got %h expected %h", i, outs, exp[i]);
        miscompares++;
      end
    end
  endtask

  // sub with a two-cycle fetch stall, then and
  task automatic test_rtype();
    vec_t       exp [10];
    logic       mr [10];
    logic [2:0] f3 [10];
    exp = '{v_fetch(0, 2'b00), v_fetch(0, 2'b00), v_fetch(1, 2'b00), v_decode(2'b00),
            v_execr(4'b0001, 2'b00), v_aluwb(2'b00),
            v_fetch(1, 2'b00), v_decode(2'b00), v_execr(4'b0010, 2'b00), v_aluwb(2'b00)};
    mr  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    f3  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111, 3'b111};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst_n = 1'b1; op = 7'b0110011; funct3 = f3[i]; funct7b5 = (i < 6); memReady = mr[i]; #1;
      vectors++;
      if (outs !== exp[i]) begin
        $display("FAIL rtype[%0d]: got %h expected %h", i, outs, exp[i]);
        miscompares++;
      end
    end
  endtask

  // addi with bit 30 set stays ADD; ori gives OR
  task automatic test_itype();
    vec_t       exp [8];
    logic [2:0] f3 [8];
    exp = '{v_fetch(1, 2'b00), v_decode(2'b00), v_execi(4'b0000, 2'b00), v_aluwb(2'b00),
            v_fetch(1, 2'b00), v_decode(2'b00), v_execi(4'b0011, 2'b00), v_aluwb(2'b00)};
    f3  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b110, 3'b110, 3'b110, 3'b110};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst_n = 1'b1; op = 7'b0010011; funct3 = f3[i]; funct7b5 = 1'b1; memReady = 1'b1; #1;
      vectors++;
      if (outs !== exp[i]) begin
        $display("FAIL itype[%0d]: got %h expected %h", i, outs, exp[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_beq();
    vec_t       exp [6];
    logic [3:0] fl [6];
    exp = '{v_fetch(1, 2'b10), v_decode(2'b10), v_branch(1, 2'b10),
            v_fetch(1, 2'b10), v_decode(2'b10), v_branch(0, 2'b10)};
    fl  = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst_n = 1'b1; op = 7'b1100011; funct3 = 3'b000; flags = fl[i]; memReady = 1'b1; #1;
      vectors++;
      if (outs !== exp[i]) begin
        $display("FAIL beq[%0d]: got %h expected %h", i, outs, exp[i]);
        miscompares++;
      end
    end
  endtask

  task automatic test_jal();
    vec_t exp [4];
    exp = '{v_fetch(1, 2'b11), v_decode(2'b11), v_jal(2'b11), v_aluwb(2'b11)};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst_n = 1'b1; op = 7'b1101111; memReady = 1'b1; #1;
      vectors++;
      if (outs !== exp[i]) begin
        $display("FAIL jal[%0d]: got %h expected %h", i, outs, exp[i]);
        miscompares++;
      end
    end
  endtask

  // lw with a read stall, reset asserted in MEMWB must kill RegWrite at once
  task automatic test_abort();
    vec_t exp [6];
    logic mr [6];
    exp = '{v_fetch(1, 2'b00), v_decode(2'b00), v_memadr(2'b00), v_memread(2'b00),
            v_memread(2'b00), v_rst(2'b00)};
    mr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst_n = (i != 5); op = 7'b0000011; funct3 = 3'b010; memReady = mr[i]; #1;
      vectors++;
      if (outs !== exp[i]) begin
        $display("FAIL abort[%0d]: got %h expected %h", i, outs, exp[i]);
        miscompares++;
      end
    end
  endtask

  // R-type funct3=001 traps after EXECUTER (ALUControl there is don't-care)
  task automatic test_alu_illegal();
    vec_t exp [6];
    exp = '{v_fetch(1, 2'b00), v_decode(2'b00), v_execr(4'b0000, 2'b00),
            v_trap(2'b00), v_trap(2'b00), v_rst(2'b00)};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst_n = (i != 5); op = 7'b0110011; funct3 = 3'b001; funct7b5 = 1'b0; memReady = 1'b1; #1;
      if (i != 2) begin
        vectors++;
        if (outs !== exp[i]) begin
          $display("FAIL alu_illegal[%0d]: got %h expected %h", i, outs, exp[i]);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_branch_ext();
    logic [2:0] bad_f3;
    vec_t       texp [5];
`ifdef BRANCH_EXT_EN
    vec_t       exp [12];
    logic [2:0] f3 [4];
    logic [3:0] fl [4];
    // bltu C=0 taken, bgeu C=0 not taken, bne Z=1 taken, blt N=1 V=0 taken
    f3  = '{3'b110, 3'b111, 3'b001, 3'b100};
    fl  = '{4'b0000, 4'b0000, 4'b0100, 4'b1000};
    exp = '{v_fetch(1, 2'b10), v_decode(2'b10), v_branch(1, 2'b10),
            v_fetch(1, 2'b10), v_decode(2'b10), v_branch(0, 2'b10),
            v_fetch(1, 2'b10), v_decode(2'b10), v_branch(1, 2'b10),
            v_fetch(1, 2'b10), v_decode(2'b10), v_branch(1, 2'b10)};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst_n = 1'b1; op = 7'b1100011; funct3 = f3[i/3]; flags = fl[i/3]; memReady = 1'b1; #1;
      vectors++;
      if (outs !== exp[i]) begin
        $display("FAIL branch_ext[%0d]: got %h expected %h", i, outs, exp[i]);
        miscompares++;
      end
    end
    bad_f3 = 3'b010;
`else
    bad_f3 = 3'b001;
`endif
    texp = '{v_fetch(1, 2'b10), v_decode(2'b10), v_trap(2'b10), v_trap(2'b10), v_rst(2'b10)};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst_n = (i != 4); op = 7'b1100011; funct3 = bad_f3; flags = 4'b0100; memReady = 1'b1; #1;
      vectors++;
      if (outs !== texp[i]) begin
        $display("FAIL branch_trap[%0d]: got %h expected %h", i, outs, texp[i]);
        miscompares++;
      end
    end
  endtask

  // Unsupported opcode: sticky TRAP for 10 cycles, reset pulse, back to FETCH
  task automatic test_trap();
    vec_t exp [14];
    exp[0] = v_fetch(1, 2'b00);
    exp[1] = v_decode(2'b00);
    for (int k = 2; k < 12; k++) exp[k] = v_trap(2'b00);
    exp[12] = v_rst(2'b00);
    exp[13] = v_fetch(1, 2'b00);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst_n = (i != 12); op = 7'b1110011; funct3 = 3'b000;
      memReady = (i < 2 || i >= 12) ? 1'b1 : 1'(i % 2); #1;
      vectors++;
      if (outs !== exp[i]) begin
        $display("FAIL trap[%0d]: got %h expected %h", i, outs, exp[i]);
        miscompares++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype();
    test_itype();
    test_beq();
    test_jal();
    test_abort();
    test_alu_illegal();
    test_branch_ext();
    test_trap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, vectors %0d", vectors);
    $fatal(1);
  end

endmodule
